// File: rtl/univ_shift_register_if.sv
// Control, data and status bundle for univ_shift_register.
// The design takes the slave view; a driver or bench takes the master view.
interface univ_shift_register_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
);
    logic          en;
    logic [1:0]    mode;
    logic          rot;
    logic          SI_R;
    logic          SI_L;
    logic [N-1:0]  I;
    logic [N-1:0]  Q;
    logic          SO_R;
    logic          SO_L;
    logic [CW-1:0] cnt;
    logic          done;

    modport master (
        output en, mode, rot, SI_R, SI_L, I,
        input  Q, SO_R, SO_L, cnt, done
    );

    modport slave (
        input  en, mode, rot, SI_R, SI_L, I,
        output Q, SO_R, SO_L, cnt, done
    );
endinterface

// File: rtl/univ_shift_register.sv
// N-bit universal shift register: hold, shift right/left (optionally rotating),
// parallel load, and a saturating shift counter that flags a full word shifted.
module univ_shift_register #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input logic                   clk,
    input logic                   reset,
    univ_shift_register_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CW-1:0] CNT_FULL = CW'(N);

    logic [N-1:0]  q, q_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          done, done_next;
    logic          shifting;
    mode_e         op;

    assign op = mode_e'(bus.mode);

    always_comb begin
        q_next    = q;
        cnt_next  = cnt;
        done_next = done;
        shifting  = 1'b0;
        if (bus.en) begin
            case (op)
                MODE_SHR: begin
                    q_next   = {(bus.rot ? q[0] : bus.SI_R), q[N-1:1]};
                    shifting = 1'b1;
                end
                MODE_SHL: begin
                    q_next   = {q[N-2:0], (bus.rot ? q[N-1] : bus.SI_L)};
                    shifting = 1'b1;
                end
                MODE_LOAD: begin
                    q_next    = bus.I;
                    cnt_next  = '0;
                    done_next = 1'b0;
                end
                default: ;
            endcase
        end
        // Counter saturates at N; shifting itself carries on past that point.
        if (shifting && (cnt != CNT_FULL)) begin
            cnt_next  = cnt + CW'(1);
            done_next = (cnt + CW'(1)) == CNT_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_next;
            cnt  <= cnt_next;
            done <= done_next;
        end
    end

    assign bus.Q    = q;
    assign bus.SO_R = q[0];
    assign bus.SO_L = q[N-1];
    assign bus.cnt  = cnt;
    assign bus.done = done;
endmodule

// File: doc/univ_shift_register.md
# univ_shift_register

Parametrised universal shift register: N-bit register with hold, shift-right, shift-left and parallel-load modes, optional rotate, and a shift counter that flags when a full word has been shifted since the last load. It is the general-purpose serialiser/deserialiser element for the registers module. It replaces fixed right-shift-with-load instances wherever bidirectional shifting, rotation or frame-completion tracking is needed.

## Interface

Parameters:
- N, default 8: register width in bits; N ≥ 2.
- CW, default $clog2(N+1): shift-counter width; must hold the value N.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operation enable; 0 forces hold regardless of mode.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rot  input  1  1 = shifts rotate, and the serial inputs are ignored; 0 = shifts take serial inputs.
- SI_R  input  1  serial in for right shift; enters at bit N-1.
- SI_L  input  1  serial in for left shift; enters at bit 0.
- I  input  N  parallel load data.
- Q  output  N  register contents.
- SO_R  output  1  right-shift serial out = Q[0].
- SO_L  output  1  left-shift serial out = Q[N-1].
- cnt  output  CW  shifts performed since last load or reset, saturating at N.
- done  output  1  high when cnt == N.

## Operation

- Priority per rising edge: reset > en==0 (hold) > mode.
- Reset: Q=0, cnt=0, done=0. SO_R and SO_L are 0 as a consequence.
- Hold (en=0 or mode=00): Q and cnt unchanged.
- Shift right, rot=0: Q ← {SI_R, Q[N-1:1]}. With rot=1: Q ← {Q[0], Q[N-1:1]}.
- Shift left, rot=0: Q ← {Q[N-2:0], SI_L}. With rot=1: Q ← {Q[N-2:0], Q[N-1]}.
- Load: Q ← I; cnt ← 0.
- Each shift in either direction, rotating or not, increments cnt by 1.
  - cnt saturates at N.
  - Shifting continues normally after saturation.
- Direction may change between cycles without penalty. Mixed-direction shifts all count.
- done is a registered level, not a pulse. It stays high until the next load or reset.
- rot is sampled only in shift modes. It has no effect on load or hold.
- Counter arithmetic is unsigned, CW bits wide. No wrap is allowed: at N, the counter stays at N.

## Timing

- All outputs come from registers or are direct bit-selects of registers. There is no combinational path from any input to any output.
- Latency: an operation presented in cycle k is visible on Q, cnt and done after edge k+1.
- done rises on the same edge on which cnt becomes N. After a load, that is the Nth qualifying shift edge.
- Reset mid-burst: on the reset edge, Q=0, cnt=0 and done=0, regardless of mode or en in that cycle.
- Load on the cycle after done=1: Q=I, cnt=0 and done=0 on the next edge.
- en toggled low mid-burst: cnt freezes, and the burst resumes counting when en returns high.

## Test plan

- Reset and load, N=8: hold reset 2 cycles → Q=0x00, cnt=0, done=0. Then mode=11, I=0xA5 → Q=0xA5, cnt=0, SO_R=1, SO_L=1.
- Right-shift burst: from 0xA5, mode=01, rot=0, SI_R=1 for 8 cycles.
  - After 1 edge: Q=0xD2, cnt=1.
  - After 8 edges: Q=0xFF, cnt=8, done=1.
  - A 9th shift leaves cnt=8 and done=1.
- Left shift and rotate:
  - Load 0x81, then mode=10, SI_L=0 → Q=0x02.
  - Load 0x81, then mode=10, rot=1 → Q=0x03.
  - Load 0x01, then mode=01, rot=1 → Q=0x80.
  - Each case gives cnt=1.
- Enable gating: load 0x3C, then shift right 3 edges with SI_R=0 → Q=0x07, cnt=3. Then en=0 for 4 cycles with mode=01 → Q=0x07, cnt=3 unchanged.
- Reset mid-operation: at cnt=5 during a right-shift burst, assert reset for 1 edge with mode=11, I=0xFF → Q=0x00, cnt=0, done=0. Reset wins over load.
- Load after done: with done=1, apply mode=11, I=0x5A → Q=0x5A, cnt=0, done=0 one edge later.
